i2s_rx: RTL
===========

Name: i2s_rx

Overview:
- I2S receiver; the receive end of the I2S link that the capture top drives outbound.
- Samples external codec b_clk, lr_clk and serial data in the system clk domain (44 MHz), deserialises left/right words and presents one stereo frame per valid/ready handshake.
- Output feeds the capture RAM write path in place of the sinc3 decimator.
- Detects slot-length errors and downstream overflow.

Parameters:
- DATA_WIDTH, 16, bits kept per channel; MSB-first, first DATA_WIDTH bits of each slot.
- SLOT_WIDTH, 32, b_clk cycles per channel slot; must be >= DATA_WIDTH.

Ports:
- clk  input  1  system clock, 44 MHz.
- reset_n  input  1  synchronous reset, active-low.
- b_clk  input  1  external bit clock; asynchronous to clk.
- lr_clk  input  1  external word select; 0 = left, 1 = right; asynchronous.
- i2s_in  input  1  external serial data; asynchronous.
- sample_l  output  DATA_WIDTH  left word of held frame.
- sample_r  output  DATA_WIDTH  right word of held frame.
- out_valid  output  1  held frame valid.
- out_ready  input  1  consumer accepts frame when out_valid && out_ready.
- frame_err  output  1  one-clk pulse on slot-length mismatch.
- overflow  output  1  sticky: frame dropped while holding register was full.
- overflow_clr  input  1  clears overflow; has priority over a new set in the same cycle.

Behaviour:
- Reset (reset_n = 0 at a clk edge): sample_l/sample_r = 0; out_valid, frame_err, overflow = 0; locked = 0; bit counter = 0; shift registers = 0.
- Synchronisers: b_clk, lr_clk and i2s_in each pass through 3 flops.
- Rise event: a cycle where synced b_clk[2:1] == 01. lr and data are sampled from the same synchronised stage.
- Timing requirement: b_clk high and low phases are each >= 3 clk periods (64 x 44.1 kHz b_clk = 2.82 MHz meets this).
- Bit position on each rise:
  - pos = cnt + 1.
  - If pos <= DATA_WIDTH, shift the data bit into the active shift register, MSB first.
- Normal rise (lr unchanged): cnt <= cnt + 1, saturating at SLOT_WIDTH.
- Rise with lr change (lr != lr_last):
  - This bit is the LSB position of the old slot, per the I2S one-bit delay.
  - Capture it if pos <= DATA_WIDTH.
  - Commit the word to the channel given by lr_last.
  - Then cnt <= 0 and lr_last <= lr.
- Lock:
  - The first lr change after reset sets locked = 1.
  - Words committed before lock, and the lock-causing word, are discarded.
- Slot check at commit:
  - If pos != SLOT_WIDTH: frame_err pulses 1 cycle and the word is discarded.
  - A discarded left word prevents the following right word from forming a frame.
- Frame complete: a valid right word commits (lr 1 -> 0) while a valid left word is pending.
  - If the holding register is empty, or out_ready = 1 in the same cycle: load sample_l/sample_r; out_valid = 1 on the next cycle. The simultaneous accept-and-load produces no overflow.
  - Else: drop the frame, keep the held frame, set overflow.
- out_valid falls on the cycle after a handshake with no new frame.
- Latency: pin edge to out_valid is <= 5 clk (3 sync, 1 detect, 1 register).
- State machine:
  - UNLOCKED -> LEFT/RIGHT on first lr change.
  - LEFT <-> RIGHT on each lr change.
  - Any state -> UNLOCKED on reset.
  - Reset mid-word discards all partial data.

Decomposition:
- Package i2s_pkg holds:
  - typedef rx_state_t {UNLOCKED, LEFT, RIGHT};
  - constant for synchroniser depth (3);
  - typedef stereo_frame_t {left, right} of DATA_WIDTH each, shared with the i2s transmitter.
- Sub-module sync_edge: 3-flop synchroniser with registered rise output. Three instances: b_clk (with rise), lr_clk, i2s_in.

Test Plan:
- Reset/idle: hold reset_n = 0 for 4 clk with b_clk toggling -> all outputs 0; release with no lr change -> out_valid stays 0.
- Basic frame: 64 b_clk/frame, 7 clk per half-period; send partial lock frame, then L = 16'hC2A3, R = 16'h43F5 with 16 zero pad bits; out_ready = 1 -> one out_valid pulse, sample_l = C2A3, sample_r = 43F5, frame_err = 0.
- Back-pressure: out_ready = 0 across two frames (7788, 1234) -> held frame stays 7788/1234 from the first frame; overflow = 1 after the second frame; overflow_clr pulse -> overflow = 0.
- Simultaneous: assert out_ready exactly in the cycle the next frame completes -> new frame loaded, overflow stays 0.
- Slot error: shorten the left slot to 30 b_clk -> one frame_err pulse; that frame is not emitted; the next correct frame is emitted normally.
- Mid-word reset: drop reset_n for 1 clk during the right slot -> out_valid = 0; the first frame after re-lock carries the correct values (e.g. FFFF/0001).

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive/transmit path
package i2s_pkg;

  // Number of flops each asynchronous pin passes through before use
  localparam int SYNC_DEPTH = 3;

  // Word width used by the shared stereo frame type
  localparam int I2S_DATA_WIDTH = 16;

  // Receiver channel-tracking state
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } rx_state_t;

  // One stereo frame as exchanged with the capture path and the transmitter
  typedef struct packed {
    logic [I2S_DATA_WIDTH-1:0] left;
    logic [I2S_DATA_WIDTH-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop pin synchroniser with registered rising-edge strobe
module sync_edge
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sr;

  // The strobe is computed from the last two stages, so q (the last stage) in the
  // cycle the strobe is high holds the level seen when the edge was detected.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr   <= '0;
      rise <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_DEPTH-2:0], d};
      rise <= sr[SYNC_DEPTH-2] & ~sr[SYNC_DEPTH-1];
    end
  end

  assign q = sr[SYNC_DEPTH-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: deserialises stereo words into a valid/ready frame
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  b_clk,
  input  logic                  lr_clk,
  input  logic                  i2s_in,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  // Counter must reach SLOT_WIDTH and pos may reach SLOT_WIDTH + 1
  localparam int CNT_W = $clog2(SLOT_WIDTH + 2);

  logic b_rise;
  logic lr_s;
  logic dat_s;
  logic bclk_s_unused;
  logic lr_rise_unused;
  logic dat_rise_unused;

  sync_edge u_sync_bclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (b_clk),
    .q       (bclk_s_unused),
    .rise    (b_rise)
  );

  sync_edge u_sync_lr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (lr_clk),
    .q       (lr_s),
    .rise    (lr_rise_unused)
  );

  sync_edge u_sync_dat (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (i2s_in),
    .q       (dat_s),
    .rise    (dat_rise_unused)
  );

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      pos;
  logic                  lr_last;
  logic                  primed;
  logic                  left_ok;
  logic [DATA_WIDTH-1:0] sh_l;
  logic [DATA_WIDTH-1:0] sh_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic                  lr_chg;
  logic                  in_data;
  logic                  slot_ok;
  logic                  commit_l;
  logic                  commit_r;
  logic                  err_evt;
  logic                  frame_done;
  logic                  ovf_set;
  logic                  load;

  // The first rise after reset only learns the lr level, so a line already
  // sitting in the right slot is not mistaken for a channel change.
  assign pos     = cnt + CNT_W'(1);
  assign lr_chg  = b_rise && primed && (lr_s != lr_last);
  assign in_data = (pos <= CNT_W'(DATA_WIDTH));
  assign slot_ok = (pos == CNT_W'(SLOT_WIDTH));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: every lr change selects the channel of the slot that now begins
  always_comb begin
    state_nxt = state;
    if (lr_chg) begin
      state_nxt = lr_s ? RIGHT : LEFT;
    end
  end

  // Commit decode; a change seen while UNLOCKED is the lock event and commits nothing
  always_comb begin
    commit_l   = lr_chg && (state == LEFT);
    commit_r   = lr_chg && (state == RIGHT);
    err_evt    = (commit_l || commit_r) && !slot_ok;
    word_r     = in_data ? {sh_r[DATA_WIDTH-2:0], dat_s} : sh_r;
    frame_done = commit_r && slot_ok && left_ok;
    ovf_set    = frame_done && out_valid && !out_ready;
    load       = frame_done && !ovf_set;
  end

  // Bit counter, lr history and MSB-first shifting into the current slot's register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      lr_last <= 1'b0;
      primed  <= 1'b0;
      sh_l    <= '0;
      sh_r    <= '0;
    end else if (b_rise) begin
      primed  <= 1'b1;
      lr_last <= lr_s;
      if (lr_chg) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(SLOT_WIDTH)) begin
        cnt <= pos;
      end
      if (in_data) begin
        if (lr_last) begin
          sh_r <= {sh_r[DATA_WIDTH-2:0], dat_s};
        end else begin
          sh_l <= {sh_l[DATA_WIDTH-2:0], dat_s};
        end
      end
    end
  end

  // sh_l stays untouched through the right slot, so it doubles as the pending left word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_ok <= 1'b0;
    end else if (commit_l) begin
      left_ok <= slot_ok;
    end else if (commit_r || (state == UNLOCKED)) begin
      left_ok <= 1'b0;
    end
  end

  // Holding register, error pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_l  <= '0;
      sample_r  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_evt;
      if (load) begin
        sample_l  <= sh_l;
        sample_r  <= word_r;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (overflow_clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
